// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with double-buffered loading,
// per-digit enable/dp and anti-ghost blanking. Define SEG7_DIM_EN to add the bright_i dimming port.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_BITS     = 18,
    parameter int BLANK_CYCLES = 2,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk_i,
    input  logic                    clr_i,
    input  logic [4*NUM_DIGITS-1:0] x_i,
    input  logic [NUM_DIGITS-1:0]   dp_in_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic                    load_i,
`ifdef SEG7_DIM_EN
    input  logic [3:0]              bright_i,
`endif
    output logic [6:0]              a_to_g_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    dp_o,
    output logic                    busy_o,
    output logic                    frame_tick_o
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_BITS-1:0] CNT_MAX  = '1;
    localparam logic [DIV_BITS-1:0] CNT_PRE  = CNT_MAX - DIV_BITS'(1);
    localparam logic [DIV_BITS-1:0] BLANK_TH = DIV_BITS'(BLANK_CYCLES);

    logic [DIV_BITS-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] stageX_q, stageX_d, actX_q, actX_d;
    logic [NUM_DIGITS-1:0]   stageDp_q, stageDp_d, actDp_q, actDp_d;
    logic [NUM_DIGITS-1:0]   stageEn_q, stageEn_d, actEn_q, actEn_d;
    logic                    busy_q, busy_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    dp_q, dp_d;
    logic                    tick_q, tick_d;

    logic                    slotEnd, frameWrap, lit;
    logic [IDX_W+1:0]        codeBase;
    logic [3:0]              curCode;
    logic                    curEn, curDp;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] seg;
        seg = 7'h7F;
        case (code)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = (HEX_MODE != 0) ? 7'h08 : 7'h3F;
            4'hB: seg = (HEX_MODE != 0) ? 7'h03 : 7'h7F;
            4'hC: seg = (HEX_MODE != 0) ? 7'h46 : 7'h77;
            4'hD: seg = (HEX_MODE != 0) ? 7'h21 : 7'h7F;
            4'hE: seg = (HEX_MODE != 0) ? 7'h06 : 7'h7F;
            4'hF: seg = (HEX_MODE != 0) ? 7'h0E : 7'h7F;
        endcase
        return seg;
    endfunction

    // Scan timing, double-buffer handoff and next pin values; pins lag idx/cnt by one cycle.
    always_comb begin
        cnt_d     = cnt_q + DIV_BITS'(1);
        slotEnd   = (cnt_q == CNT_MAX);
        frameWrap = slotEnd && (idx_q == LAST_IDX);
        idx_d     = idx_q;
        if (slotEnd) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        stageX_d  = stageX_q;
        stageDp_d = stageDp_q;
        stageEn_d = stageEn_q;
        if (load_i) begin
            stageX_d  = x_i;
            stageDp_d = dp_in_i;
            stageEn_d = digit_en_i;
        end

        actX_d  = actX_q;
        actDp_d = actDp_q;
        actEn_d = actEn_q;
        if (frameWrap && busy_q) begin
            actX_d  = stageX_q;
            actDp_d = stageDp_q;
            actEn_d = stageEn_q;
        end

        // A load landing on the boundary cycle re-arms busy after the old staging is consumed.
        busy_d = busy_q;
        if (frameWrap) begin
            busy_d = 1'b0;
        end
        if (load_i) begin
            busy_d = 1'b1;
        end

        codeBase = {idx_q, 2'b00};
        curCode  = actX_q[codeBase +: 4];
        curEn    = actEn_q[idx_q];
        curDp    = actDp_q[idx_q];
`ifdef SEG7_DIM_EN
        lit = curEn && (cnt_q >= BLANK_TH) && (cnt_q[DIV_BITS-1 -: 4] < bright_i);
`else
        lit = curEn && (cnt_q >= BLANK_TH);
`endif

        an_d = '1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
        end
        seg_d  = curEn ? decode(curCode) : 7'h7F;
        dp_d   = ~(curDp & lit);
        tick_d = (cnt_q == CNT_PRE) && (idx_q == LAST_IDX);
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            stageX_q  <= '0;
            stageDp_q <= '0;
            stageEn_q <= '0;
            actX_q    <= '0;
            actDp_q   <= '0;
            actEn_q   <= '0;
            busy_q    <= 1'b0;
            seg_q     <= 7'h7F;
            an_q      <= '1;
            dp_q      <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stageX_q  <= stageX_d;
            stageDp_q <= stageDp_d;
            stageEn_q <= stageEn_d;
            actX_q    <= actX_d;
            actDp_q   <= actDp_d;
            actEn_q   <= actEn_d;
            busy_q    <= busy_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
            tick_q    <= tick_d;
        end
    end

    assign a_to_g_o     = seg_q;
    assign an_o         = an_q;
    assign dp_o         = dp_q;
    assign busy_o       = busy_q;
    assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: a 4-digit instance checked cycle by cycle against a
// time-based reference model, plus a 3-digit HEX_MODE=1 instance for scan period and glyphs.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int DB = 4;
    localparam int S  = 16;
    localparam int BL = 2;
`ifdef SEG7_DIM_EN
    localparam bit DIM = 1'b1;
`else
    localparam bit DIM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] x = '0;
    logic [3:0]  dpIn = '0, digEn = '0;
    logic        load = 1'b0;
    logic [3:0]  bright = 4'hF;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp, busy, ft;

    logic [11:0] x3 = '0;
    logic [2:0]  dpIn3 = '0, digEn3 = '0;
    logic        load3 = 1'b0;
    logic [6:0]  seg3;
    logic [2:0]  an3;
    logic        dp3, busy3, ft3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(ND), .DIV_BITS(DB), .BLANK_CYCLES(BL), .HEX_MODE(0)) dut (
        .clk_i(clk), .clr_i(clr), .x_i(x), .dp_in_i(dpIn), .digit_en_i(digEn), .load_i(load),
`ifdef SEG7_DIM_EN
        .bright_i(bright),
`endif
        .a_to_g_o(seg), .an_o(an), .dp_o(dp), .busy_o(busy), .frame_tick_o(ft)
    );

    seg7_scan_driver #(.NUM_DIGITS(3), .DIV_BITS(DB), .BLANK_CYCLES(BL), .HEX_MODE(1)) dut3 (
        .clk_i(clk), .clr_i(clr), .x_i(x3), .dp_in_i(dpIn3), .digit_en_i(digEn3), .load_i(load3),
`ifdef SEG7_DIM_EN
        .bright_i(bright),
`endif
        .a_to_g_o(seg3), .an_o(an3), .dp_o(dp3), .busy_o(busy3), .frame_tick_o(ft3)
    );

    // Reference model: position in the scan is derived purely from cycles since reset.
    int          mT;
    logic [15:0] mSx, mAx;
    logic [3:0]  mSdp, mSen, mAdp, mAen;
    logic        mPend, expFt, expDp;
    logic [6:0]  expSeg;
    logic [3:0]  expAn;

    function automatic logic [6:0] refGlyph(input logic [3:0] code);
        case (code)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h3F;  4'hC: return 7'h77;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic bit wrapAt(input int t);
        return ((t % S) == S - 1) && (((t / S) % ND) == ND - 1);
    endfunction

    function automatic bit litAt(input int t, input logic [3:0] en, input logic [3:0] br);
        int c = t % S;
        int d = (t / S) % ND;
        return (en[d] == 1'b1) && (c >= BL) && (!DIM || ((c / (S / 16)) < int'(br)));
    endfunction

    function automatic logic [3:0] anAt(input int t, input logic [3:0] en, input logic [3:0] br);
        logic [3:0] one = 4'b0001;
        return litAt(t, en, br) ? ~(one << ((t / S) % ND)) : 4'hF;
    endfunction

    function automatic logic [6:0] segAt(input int t, input logic [15:0] ax, input logic [3:0] en);
        int d = (t / S) % ND;
        return en[d] ? refGlyph(ax[4*d +: 4]) : 7'h7F;
    endfunction

    function automatic logic dpAt(input int t, input logic [3:0] adp, input logic [3:0] en,
                                  input logic [3:0] br);
        int d = (t / S) % ND;
        return ~(adp[d] & litAt(t, en, br));
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            mT <= 0;
            mSx <= '0; mSdp <= '0; mSen <= '0;
            mAx <= '0; mAdp <= '0; mAen <= '0;
            mPend <= 1'b0;
            expSeg <= 7'h7F; expAn <= 4'hF; expDp <= 1'b1; expFt <= 1'b0;
        end else begin
            expAn  <= anAt(mT, mAen, bright);
            expSeg <= segAt(mT, mAx, mAen);
            expDp  <= dpAt(mT, mAdp, mAen, bright);
            expFt  <= wrapAt(mT + 1);
            if (wrapAt(mT) && mPend) begin
                mAx <= mSx; mAdp <= mSdp; mAen <= mSen;
            end
            if (load) begin
                mSx <= x; mSdp <= dpIn; mSen <= digEn;
            end
            mPend <= load ? 1'b1 : (wrapAt(mT) ? 1'b0 : mPend);
            mT <= mT + 1;
        end
    end

    wire [13:0] obsV = {seg, an, dp, busy, ft};
    wire [13:0] expV = {expSeg, expAn, expDp, mPend, expFt};

    task automatic waitTick(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            load = 1'b0;
            load3 = 1'b0;
            if (ft === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({obsV, seg3, an3, dp3, busy3, ft3} !== {7'h7F, 4'hF, 3'b100, 7'h7F, 3'h7, 3'b100}) begin
            errors++;
            $display("[TB] FAIL reset_initial: got %h/%h %h, required 7f f 1 0 0", obsV, seg3, an3);
        end
        clr = 1'b0;
        x = 16'h9876; digEn = 4'hF; dpIn = 4'h3; load = 1'b1;
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            load = 1'b0;
            checks++;
            if (obsV !== expV) begin
                errors++;
                $display("[TB] FAIL reset_prescan t=%0t: got %h, required %h", $time, obsV, expV);
            end
        end
        clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) clr = 1'b0;
            checks++;
            if ({obsV, seg3, an3, dp3, busy3, ft3} !== {7'h7F, 4'hF, 3'b100, 7'h7F, 3'h7, 3'b100}) begin
                errors++;
                $display("[TB] FAIL reset_midscan cycle %0d: got %h/%h %h, required 7f f 1 0 0",
                         i, obsV, seg3, an3);
            end
        end
        @(negedge clk);
        checks++;
        if (obsV !== {7'h7F, 4'hF, 3'b100}) begin
            errors++;
            $display("[TB] FAIL reset_first_after: got %h, required %h", obsV, {7'h7F, 4'hF, 3'b100});
        end
    endtask

    task automatic test_scan();
        logic [6:0] glyph [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
        logic [3:0] one = 4'b0001;
        int lowCnt [4] = '{0, 0, 0, 0};
        int firstK [4] = '{-1, -1, -1, -1};
        int expLow = DIM ? 13 : 14;
        bit found;
        x = 16'h4321; digEn = 4'hF; dpIn = 4'h0; load = 1'b1;
        waitTick(found);
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL scan_tick_timeout: got no frame_tick, required one within 200 cycles");
            return;
        end
        for (int k = 0; k <= 64; k++) begin
            @(negedge clk);
            checks++;
            if (obsV !== expV) begin
                errors++;
                $display("[TB] FAIL scan_model t=%0t: got %h, required %h", $time, obsV, expV);
            end
            if (k >= 1 && an !== 4'hF) begin
                bit known = 1'b0;
                for (int d = 0; d < 4; d++) begin
                    if (an === ~(one << d)) begin
                        known = 1'b1;
                        lowCnt[d]++;
                        if (firstK[d] < 0) firstK[d] = k;
                        checks++;
                        if (seg !== glyph[d]) begin
                            errors++;
                            $display("[TB] FAIL scan_glyph d%0d: got %h, required %h", d, seg, glyph[d]);
                        end
                    end
                end
                checks++;
                if (!known) begin
                    errors++;
                    $display("[TB] FAIL scan_one_hot: got an=%h, required one low bit", an);
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (lowCnt[d] != expLow || (d > 0 && firstK[d] <= firstK[d-1])) begin
                errors++;
                $display("[TB] FAIL scan_order d%0d: got %0d low cycles first at %0d, required %0d after d%0d",
                         d, lowCnt[d], firstK[d], expLow, d - 1);
            end
        end
    endtask

    task automatic test_double_buffer();
        int guard;
        for (int i = 0; i < 20; i++) @(negedge clk);
        x = 16'h1111; load = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            load = 1'b0;
            guard++;
            checks++;
            if (obsV !== expV || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL dbuf_hold t=%0t: got %h busy=%b, required %h busy=1", $time, obsV, busy, expV);
            end
        end while (ft !== 1'b1 && guard < 100);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || guard >= 100) begin
            errors++;
            $display("[TB] FAIL dbuf_release: got busy=%b after %0d cycles, required busy=0", busy, guard);
        end
        for (int i = 0; i < 10; i++) @(negedge clk);
        x = 16'h2222; load = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            load = 1'b0;
            guard++;
        end while (ft !== 1'b1 && guard < 100);
        x = 16'h3333; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1 || obsV !== expV) begin
            errors++;
            $display("[TB] FAIL dbuf_load_on_tick: got %h busy=%b, required %h busy=1", obsV, busy, expV);
        end
        guard = 0;
        while (ft !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dbuf_second_release: got busy=%b, required 0", busy);
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            checks++;
            if (obsV !== expV || (an !== 4'hF && seg !== 7'h30)) begin
                errors++;
                $display("[TB] FAIL dbuf_new_data t=%0t: got %h, required %h with seg 30", $time, obsV, expV);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        for (int i = 0; i < 5; i++) @(negedge clk);
        x = 16'h5555; load = 1'b1;
        @(negedge clk);
        x = 16'h6666;
        waitTick(found);
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            checks++;
            if (!found || obsV !== expV || (an !== 4'hF && seg !== 7'h02)) begin
                errors++;
                $display("[TB] FAIL back_to_back t=%0t: got %h, required %h with seg 02", $time, obsV, expV);
            end
        end
    endtask

    task automatic test_enable_dp();
        bit found;
        x = 16'($urandom); digEn = 4'b0101; dpIn = 4'b0001; load = 1'b1;
        waitTick(found);
        @(negedge clk);
        for (int i = 0; i < 192; i++) begin
            @(negedge clk);
            checks++;
            if (!found || obsV !== expV || an[1] !== 1'b1 || an[3] !== 1'b1 || ((dp === 1'b0) != (an[0] === 1'b0))) begin
                errors++;
                $display("[TB] FAIL enable_dp t=%0t: got %h, required %h", $time, obsV, expV);
            end
        end
    endtask

    task automatic test_three_digit();
        int lastFt3 = -1, firstFt3 = -1, first4 = -1, nFt3 = 0;
        x3 = 12'h1AE; digEn3 = 3'h7; dpIn3 = 3'h0; load3 = 1'b1;
        x = 16'hEEEE; digEn = 4'hF; dpIn = 4'h0; load = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            load = 1'b0; load3 = 1'b0;
            checks++;
            if (obsV !== expV || an3 === 3'b000) begin
                errors++;
                $display("[TB] FAIL three_scan t=%0t: got %h an3=%b, required %h an3 not 000", $time, obsV, an3, expV);
            end
            if (ft3 === 1'b1) begin
                if (lastFt3 >= 0) begin
                    checks++;
                    if (cyc - lastFt3 != 48) begin
                        errors++;
                        $display("[TB] FAIL three_period: got %0d cycles, required 48", cyc - lastFt3);
                    end
                end else begin
                    firstFt3 = cyc;
                end
                lastFt3 = cyc;
                nFt3++;
            end
            if (ft === 1'b1 && first4 < 0) first4 = cyc;
            if (firstFt3 >= 0 && cyc >= firstFt3 + 2 && (an3 === 3'b110 || an3 === 3'b101)) begin
                checks++;
                if (seg3 !== ((an3 === 3'b110) ? 7'h06 : 7'h08)) begin
                    errors++;
                    $display("[TB] FAIL hex_glyph an3=%b: got %h, required %h", an3, seg3,
                             (an3 === 3'b110) ? 7'h06 : 7'h08);
                end
            end
            if (first4 >= 0 && cyc >= first4 + 2 && an !== 4'hF) begin
                checks++;
                if (seg !== 7'h7F) begin
                    errors++;
                    $display("[TB] FAIL legacy_E: got %h, required 7f", seg);
                end
            end
        end
        checks++;
        if (nFt3 < 3) begin
            errors++;
            $display("[TB] FAIL three_tick_count: got %0d ticks, required at least 3", nFt3);
        end
    endtask

`ifdef SEG7_DIM_EN
    task automatic test_dim();
        x = 16'($urandom); digEn = 4'hF; dpIn = 4'($urandom); load = 1'b1; bright = 4'd4;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (i == 150) bright = 4'd0;
            checks++;
            if (obsV !== expV || (i > 150 && an !== 4'hF)) begin
                errors++;
                $display("[TB] FAIL dim t=%0t bright=%0d: got %h, required %h", $time, bright, obsV, expV);
            end
        end
        bright = 4'hF;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            checks++;
            if (obsV !== expV) begin
                errors++;
                $display("[TB] FAIL random t=%0t: got %h, required %h", $time, obsV, expV);
            end
            clr = 1'b0;
            load = 1'b0;
            if ($urandom_range(0, 399) == 0) begin
                clr = 1'b1;
            end else if ($urandom_range(0, 11) == 0) begin
                x = 16'($urandom); dpIn = 4'($urandom); digEn = 4'($urandom); load = 1'b1;
            end
            if (DIM && $urandom_range(0, 63) == 0) bright = 4'($urandom);
        end
        clr = 1'b0;
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_double_buffer();
        test_back_to_back();
        test_enable_dp();
        test_three_digit();
`ifdef SEG7_DIM_EN
        test_dim();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
